conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
Streaming 3x3 sliding-window generator directly upstream of the 3x3 convolution MAC stage. Accepts one pixel per cycle in raster order and buffers two full image rows in line buffers. Presents the nine window taps p00..p22 with a valid strobe, ready to drive the MAC stage's window inputs and valid_in. Valid-mode convolution: no padding, (IMG_W-2)*(IMG_H-2) windows per frame at stride 1.

Parameters:
DATA_BITS, 8, pixel width (signed), matches MAC stage pixel width
IMG_W, 32, pixels per row (>=3)
IMG_H, 32, rows per frame (>=3)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  pixel_in valid this cycle
pixel_in  input  DATA_BITS  signed pixel, raster order, row 0 col 0 first
p00..p22  output  DATA_BITS each  signed window taps, row-major; p00 oldest/top-left, p22 newest/bottom-right
valid_out  output  1  window taps valid this cycle
frame_done  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (async, rst_n low): col/row counters = 0, all p* = 0, valid_out = 0, frame_done = 0. Window shift registers are cleared; line-buffer contents need not be cleared (rows are gated by row counter).
- No backpressure. Downstream consumes every valid_out cycle.
- Accepting pixel (r,c) on valid_in=1:
  - Shifts the 3x3 register window left by one column.
  - The new right column is {linebuf1[c], linebuf0[c], pixel_in}, top to bottom.
  - linebuf1[c] <= linebuf0[c]; linebuf0[c] <= pixel_in.
- Tap mapping: p22 = pixel(r,c), p00 = pixel(r-2,c-2); general tap pij = pixel(r-2+i, c-2+j).
- Latency: outputs registered; valid_out asserts the cycle after accepting pixel (r,c) iff r>=2 and c>=2. Otherwise valid_out=0.
- p* hold last values when valid_out=0.
- valid_in gaps: no state change, valid_out=0; a window resumes exactly where the stream left off.
- Counters:
  - col increments per accepted pixel and wraps IMG_W-1 -> 0, incrementing row.
  - row wraps IMG_H-1 -> 0 (next frame starts immediately, back-to-back frames supported).
- Row wrap: stale columns from the previous row end are in the shift registers at c=0,1. They are never emitted because c<2 gates valid_out.
- frame_done = 1 in the same cycle as valid_out for window (IMG_H-1, IMG_W-1).
- Counter widths: $clog2(IMG_W), $clog2(IMG_H). Line buffers are inferred memories of depth IMG_W.
- Reset asserted mid-frame: all outputs drop to 0 immediately. The next accepted pixel is treated as (0,0).

Optional Feature:
STRIDE2_EN defined:
- valid_out asserts only when r>=2, c>=2, (r-2) even and (c-2) even.
- Window count = floor((IMG_W-1)/2)*floor((IMG_H-1)/2).
- frame_done pulses on the last emitted window of the frame, or the cycle after the last pixel if that window is not emitted.

STRIDE2_EN undefined: stride 1 as above.

Decomposition:
- Shared package cnn_pkg:
  - DATA_BITS default
  - image dimension constants
  - typedef pixel_t (signed [DATA_BITS-1:0])
- One natural sub-module: line_buffer (single-port read-before-write RAM, depth IMG_W, width DATA_BITS). Instantiated twice, chained.

Test Plan:
1. IMG_W=5, IMG_H=4, pixel=r*5+c, continuous valid -> 6 windows. First window (cycle after pixel 12): p00..p22 = 0,1,2,5,6,7,10,11,12. Last window p22=19, p00=7, with frame_done=1.
2. Same stream with valid_in toggling 1/0 each cycle -> identical 6 windows in identical order. No valid_out during gap cycles.
3. Two back-to-back frames, second frame pixel=100+r*5+c -> second frame first window p00=100, p22=112. No window mixes frames. Two frame_done pulses.
4. Negative pixels (-128..-109) -> taps sign-preserved, e.g. first window p00=-128, p22=-116.
5. Reset asserted after pixel 13 of frame 1, then restart stream -> outputs 0 during reset. First post-reset window matches test 1's first window.
6. STRIDE2_EN, IMG_W=6, IMG_H=6, pixel=r*6+c -> 4 windows with p22 = 14, 16, 26, 28. frame_done pulses with p22=28.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end: default pixel width, default
// image geometry, the pixel type and a helper for window placement.
package cnn_pkg;

  localparam int CNN_DATA_BITS = 8;
  localparam int CNN_IMG_W     = 32;
  localparam int CNN_IMG_H     = 32;

  typedef logic signed [CNN_DATA_BITS-1:0] pixel_t;

  // Index (row or column) of the last window position emitted along a
  // dimension of n pixels when windows are placed every `stride` pixels
  // starting at index 2.
  function automatic int last_win_idx(input int n, input int stride);
    return 2 + stride * ((n - 3) / stride);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. Combinational read and registered write
// on the same address give read-before-write behaviour: in the cycle a
// column is overwritten, o_rdata still shows the value from the row above.
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_addr,
  input  logic signed [WIDTH-1:0] i_wdata,
  output logic signed [WIDTH-1:0] o_rdata
);

  logic signed [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Store the incoming pixel at its column; contents are never reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator for valid-mode convolution.
// Pixels arrive one per cycle in raster order; two chained line buffers
// hold the previous two rows and a 3x2 register array holds the two most
// recent columns, so each accepted pixel completes one 3x3 window.
// Optional build macro STRIDE2_EN: emit only windows at even offsets
// (stride 2 in both directions); undefined gives stride 1.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_BITS = CNN_DATA_BITS,
  parameter int IMG_W     = CNN_IMG_W,
  parameter int IMG_H     = CNN_IMG_H
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] pixel_in,
  output logic signed [DATA_BITS-1:0] p00,
  output logic signed [DATA_BITS-1:0] p01,
  output logic signed [DATA_BITS-1:0] p02,
  output logic signed [DATA_BITS-1:0] p10,
  output logic signed [DATA_BITS-1:0] p11,
  output logic signed [DATA_BITS-1:0] p12,
  output logic signed [DATA_BITS-1:0] p20,
  output logic signed [DATA_BITS-1:0] p21,
  output logic signed [DATA_BITS-1:0] p22,
  output logic                        valid_out,
  output logic                        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
`ifdef STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);
  localparam logic [CW-1:0] COL_LAST  = CW'(last_win_idx(IMG_W, STRIDE));
  localparam logic [RW-1:0] ROW_LAST  = RW'(last_win_idx(IMG_H, STRIDE));

  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic signed [DATA_BITS-1:0]   r_c1 [3];       // oldest retained column
  logic signed [DATA_BITS-1:0]   r_c2 [3];       // newer retained column
  logic signed [DATA_BITS-1:0]   r_p  [3][3];    // registered window taps
  logic                          r_valid;
  logic                          r_done;

  logic signed [DATA_BITS-1:0]   w_lb0_q;
  logic signed [DATA_BITS-1:0]   w_lb1_q;
  logic signed [DATA_BITS-1:0]   w_win [3][3];
  logic                          w_stride_ok;
  logic                          w_emit;
  logic                          w_last;

  // Row r-1 lives in lb0, row r-2 in lb1; lb1 is refilled from lb0's output.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_BITS), .AW(CW)) u_lb0 (
    .clk     (clk),
    .i_we    (valid_in),
    .i_addr  (r_col),
    .i_wdata (pixel_in),
    .o_rdata (w_lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_BITS), .AW(CW)) u_lb1 (
    .clk     (clk),
    .i_we    (valid_in),
    .i_addr  (r_col),
    .i_wdata (w_lb0_q),
    .o_rdata (w_lb1_q)
  );

`ifdef STRIDE2_EN
  // r-2 and c-2 are even exactly when r and c are even.
  assign w_stride_ok = ~r_row[0] & ~r_col[0];
`else
  assign w_stride_ok = 1'b1;
`endif

  // Columns c<2 hold stale pixels from the previous row, so they gate output.
  assign w_emit = valid_in && (r_row >= ROW_FIRST) && (r_col >= COL_FIRST) && w_stride_ok;
  assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Assemble the window completed by the current pixel.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_win[i][0] = r_c1[i];
      w_win[i][1] = r_c2[i];
    end
    w_win[0][2] = w_lb1_q;
    w_win[1][2] = w_lb0_q;
    w_win[2][2] = pixel_in;
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Shift the retained columns left on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_c1[i] <= '0;
        r_c2[i] <= '0;
      end
    end else if (valid_in) begin
      for (int i = 0; i < 3; i++) begin
        r_c1[i] <= w_win[i][1];
        r_c2[i] <= w_win[i][2];
      end
    end
  end

  // Capture emitted windows; taps hold between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_p[i][j] <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_emit) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            r_p[i][j] <= w_win[i][j];
      end
      r_valid <= w_emit;
      r_done  <= w_emit && w_last;
    end
  end

  assign p00        = r_p[0][0];
  assign p01        = r_p[0][1];
  assign p02        = r_p[0][2];
  assign p10        = r_p[1][0];
  assign p11        = r_p[1][1];
  assign p12        = r_p[1][2];
  assign p20        = r_p[2][0];
  assign p21        = r_p[2][1];
  assign p22        = r_p[2][2];
  assign valid_out  = r_valid;
  assign frame_done = r_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: table of expected windows per frame,
// replayed for continuous, gapped, back-to-back, negative and post-reset
// streams. Builds with or without STRIDE2_EN.
module tb_conv_window_gen;
  import cnn_pkg::*;

`ifdef STRIDE2_EN
  localparam int W = 6, H = 6, NW = 4, OFF2 = 50;
`else
  localparam int W = 5, H = 4, NW = 6, OFF2 = 100;
`endif

  logic   clk = 1'b0;
  logic   rst_n;
  logic   valid_in;
  pixel_t pixel_in;
  pixel_t p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic   valid_out, frame_done;

  typedef struct {
    int t [9];
    bit fd;
  } win_t;

  win_t exp_w [NW];
  int   checks = 0;
  int   errors = 0;
  int   widx;
  int   fd_seen;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_BITS(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pixel_in(pixel_in),
    .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
    .p20(p20), .p21(p21), .p22(p22),
    .valid_out(valid_out), .frame_done(frame_done)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input bit v, input int pix, input int off);
    int act [9];
    @(negedge clk);
    valid_in = v;
    pixel_in = pixel_t'(pix);
    @(posedge clk);
    #1;
    if (valid_out) begin
      if (widx < NW) begin
        act = '{int'(p00), int'(p01), int'(p02), int'(p10), int'(p11),
                int'(p12), int'(p20), int'(p21), int'(p22)};
        for (int i = 0; i < 9; i++)
          chk($sformatf("win%0d_tap%0d", widx, i), act[i], exp_w[widx].t[i] + off);
        chk($sformatf("win%0d_frame_done", widx), int'(frame_done), int'(exp_w[widx].fd));
      end else begin
        chk("extra_window", widx, NW - 1);
      end
      if (frame_done) fd_seen++;
      widx++;
    end else begin
      chk("frame_done_idle", int'(frame_done), 0);
    end
    if (!v) chk("gap_valid_out", int'(valid_out), 0);
  endtask

  // Stream npix pixels of a frame valued off + r*W + c, optionally with a
  // one-cycle gap after every pixel.
  task automatic run_frame(input int off, input bit gaps, input int npix, input string tag);
    widx = 0;
    for (int k = 0; k < npix; k++) begin
      step(1'b1, off + k, off);
      if (gaps) step(1'b0, 0, off);
    end
    valid_in = 1'b0;
    if (npix == W * H) chk({tag, "_window_count"}, widx, NW);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid_out"}, int'(valid_out), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_p00"}, int'(p00), 0);
    chk({tag, "_p11"}, int'(p11), 0);
    chk({tag, "_p22"}, int'(p22), 0);
  endtask

  initial begin
`ifdef STRIDE2_EN
    exp_w[0] = '{'{ 0,  1,  2,  6,  7,  8, 12, 13, 14}, 1'b0};
    exp_w[1] = '{'{ 2,  3,  4,  8,  9, 10, 14, 15, 16}, 1'b0};
    exp_w[2] = '{'{12, 13, 14, 18, 19, 20, 24, 25, 26}, 1'b0};
    exp_w[3] = '{'{14, 15, 16, 20, 21, 22, 26, 27, 28}, 1'b1};
`else
    exp_w[0] = '{'{0, 1, 2,  5,  6,  7, 10, 11, 12}, 1'b0};
    exp_w[1] = '{'{1, 2, 3,  6,  7,  8, 11, 12, 13}, 1'b0};
    exp_w[2] = '{'{2, 3, 4,  7,  8,  9, 12, 13, 14}, 1'b0};
    exp_w[3] = '{'{5, 6, 7, 10, 11, 12, 15, 16, 17}, 1'b0};
    exp_w[4] = '{'{6, 7, 8, 11, 12, 13, 16, 17, 18}, 1'b0};
    exp_w[5] = '{'{7, 8, 9, 12, 13, 14, 17, 18, 19}, 1'b1};
`endif
    rst_n    = 1'b0;
    valid_in = 1'b0;
    pixel_in = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous single frame
    fd_seen = 0;
    run_frame(0, 1'b0, W * H, "continuous");
    chk("continuous_fd_pulses", fd_seen, 1);

    // Same frame with a bubble after every pixel
    fd_seen = 0;
    run_frame(0, 1'b1, W * H, "gapped");
    chk("gapped_fd_pulses", fd_seen, 1);

    // Two frames back to back, second one offset
    fd_seen = 0;
    run_frame(0, 1'b0, W * H, "b2b_frame1");
    run_frame(OFF2, 1'b0, W * H, "b2b_frame2");
    chk("b2b_fd_pulses", fd_seen, 2);

    // Negative pixels, sign must survive
    run_frame(-128, 1'b0, W * H, "negative");

    // Partial frame, then asynchronous reset between edges
    run_frame(0, 1'b0, 14, "partial");
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset_now");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("midreset_held");
    @(negedge clk);
    rst_n = 1'b1;
    fd_seen = 0;
    run_frame(0, 1'b0, W * H, "after_reset");
    chk("after_reset_fd_pulses", fd_seen, 1);

    step(1'b0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
